rng_arbiter: RTL and testbench

//  Shares the single 8-bit LFSR random source among game consumers: obstacle type, spawn gap, cloud height, etc.
//  - Owns the LFSR enable and sequences warm-up after reset.
//  - Round-robin arbitrates requesters; each grant returns a one-cycle random word.
//  - Enforces a minimum number of LFSR shifts between grants, so consumers never receive the same or trivially

---
 rtl/rng_arbiter_if.sv | 26 ++
 rtl/rng_arbiter.sv | 156 +++++++++++++++
 tb/tb_rng_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/rng_arbiter_if.sv
// Bundle between the shared-LFSR arbiter and its consumers / LFSR instance.
// slave = arbiter side, master = requesters plus the LFSR data source.
interface rng_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
);
   localparam int IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req;
   logic [WIDTH-1:0]   lfsr_data;
   logic               lfsr_en;
   logic [NUM_REQ-1:0] gnt;
   logic [IW-1:0]      gnt_id;
   logic               rnd_valid;
   logic [WIDTH-1:0]   rnd_data;

   modport slave (
      input  req, lfsr_data,
      output lfsr_en, gnt, gnt_id, rnd_valid, rnd_data
   );

   modport master (
      output req, lfsr_data,
      input  lfsr_en, gnt, gnt_id, rnd_valid, rnd_data
   );
endinterface

// File: rtl/rng_arbiter.sv
// Round-robin arbiter sharing one LFSR among consumers: warm-up after reset,
// one-cycle grant carrying the sampled LFSR word, then a GAP-cycle cooldown.

// Per-requester priority check: wins when requesting and no other requester
// sits closer to rr_ptr in the circular scan order.
module rng_arb_lane #(
   parameter int NUM_REQ = 4,
   parameter int IW      = 2,
   parameter int IDX     = 0
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      rr_ptr,
   output logic               win
);
   int my_d;
   int d;

   always_comb begin
      my_d = (IDX + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
      d    = 0;
      win  = req[IDX];
      for (int j = 0; j < NUM_REQ; j++) begin
         d = (j + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
         if (req[j] && (d < my_d)) win = 1'b0;
      end
   end
endmodule

module rng_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8,
   parameter int GAP     = 8,
   parameter int WARMUP  = 8
) (
   input  logic         clk,
   input  logic         rst,
   rng_arbiter_if.slave bus
);
   localparam int IW   = $clog2(NUM_REQ);
   localparam int MAXC = (GAP > WARMUP) ? GAP : WARMUP;
   localparam int CW   = $clog2(MAXC) + 1;
   localparam logic [CW-1:0] WARM_LAST = CW'(WARMUP - 1);
   localparam logic [CW-1:0] COOL_LAST = CW'((GAP > 1) ? GAP - 2 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WARMUP,
      S_READY,
      S_COOLDOWN
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic               lfsr_en_q, lfsr_en_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]      gnt_id_q, gnt_id_d;
   logic               rnd_valid_q, rnd_valid_d;
   logic [WIDTH-1:0]   rnd_data_q, rnd_data_d;

   logic [NUM_REQ-1:0] win;
   logic [IW-1:0]      win_id;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      rng_arb_lane #(
         .NUM_REQ (NUM_REQ),
         .IW      (IW),
         .IDX     (i)
      ) u_lane (
         .req    (bus.req),
         .rr_ptr (rr_ptr_q),
         .win    (win[i])
      );
   end

   always_comb begin
      win_id = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (win[i]) win_id = IW'(i);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_ptr_d    = rr_ptr_q;
      lfsr_en_d   = lfsr_en_q;
      gnt_d       = '0;
      gnt_id_d    = '0;
      rnd_valid_d = 1'b0;
      rnd_data_d  = '0;
      case (state_q)
         S_IDLE: begin
            state_d   = S_WARMUP;
            lfsr_en_d = 1'b1;
            cnt_d     = '0;
         end
         S_WARMUP: begin
            if (cnt_q == WARM_LAST) begin
               state_d = S_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_READY: begin
            if (|bus.req) begin
               gnt_d       = win;
               gnt_id_d    = win_id;
               rnd_valid_d = 1'b1;
               rnd_data_d  = bus.lfsr_data;
               rr_ptr_d    = (win_id == IW'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
               cnt_d       = '0;
               // With GAP==1 the next grant may follow on the very next edge.
               state_d     = (GAP == 1) ? S_READY : S_COOLDOWN;
            end
         end
         S_COOLDOWN: begin
            if (cnt_q == COOL_LAST) begin
               state_d = S_READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rr_ptr_q    <= '0;
         lfsr_en_q   <= 1'b0;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         rnd_valid_q <= 1'b0;
         rnd_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         lfsr_en_q   <= lfsr_en_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         rnd_valid_q <= rnd_valid_d;
         rnd_data_q  <= rnd_data_d;
      end
   end

   assign bus.lfsr_en   = lfsr_en_q;
   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.rnd_valid = rnd_valid_q;
   assign bus.rnd_data  = rnd_data_q;
endmodule

// File: tb/tb_rng_arbiter.sv
// Directed bench for rng_arbiter: GAP=8 instance for warm-up, round-robin,
// drop-out and mid-cooldown reset; GAP=1 instance for back-to-back grants.
module tb_rng_arbiter;
   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic rst1 = 1'b1;
   always #5 clk = ~clk;

   rng_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus0 ();
   rng_arbiter_if #(.NUM_REQ(4), .WIDTH(8)) bus1 ();

   rng_arbiter #(.NUM_REQ(4), .WIDTH(8), .GAP(8), .WARMUP(8)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   rng_arbiter #(.NUM_REQ(4), .WIDTH(8), .GAP(1), .WARMUP(8)) u_dut1 (
      .clk (clk),
      .rst (rst1),
      .bus (bus1)
   );

   // 8-bit XNOR LFSR (taps 8,6,5,4): 0x55 -> 0xAA -> 0x54 ...
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], ~(v[7] ^ v[5] ^ v[4] ^ v[3])};
   endfunction

   function automatic logic [7:0] lfsr_after(input int n);
      logic [7:0] v;
      v = 8'h55;
      for (int k = 0; k < n; k++) v = lfsr_step(v);
      return v;
   endfunction

   logic [7:0] lfsr0 = 8'h55;
   logic [7:0] lfsr1 = 8'h55;
   always @(posedge clk) lfsr0 <= bus0.lfsr_en ? lfsr_step(lfsr0) : 8'h55;
   always @(posedge clk) lfsr1 <= bus1.lfsr_en ? lfsr_step(lfsr1) : 8'h55;
   assign bus0.lfsr_data = lfsr0;
   assign bus1.lfsr_data = lfsr1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits up to bound negedges for a grant; cyc = negedges taken (-1 on
   // timeout), smp = LFSR word presented on the edge that produced it.
   task automatic wait_gnt(input int which, input int bound, output int cyc,
                           output logic [7:0] smp);
      logic done;
      cyc  = -1;
      smp  = '0;
      done = 1'b0;
      for (int i = 1; i <= bound && !done; i++) begin
         smp = (which != 0) ? lfsr1 : lfsr0;
         @(negedge clk);
         if (((which != 0) ? bus1.gnt : bus0.gnt) != 4'b0000) begin
            cyc  = i;
            done = 1'b1;
         end
      end
   endtask

   logic [3:0] rr_exp [4];
   int         cyc;
   int         spur;
   logic [7:0] smp;

   initial begin
      rr_exp    = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
      bus0.req  = '0;
      bus1.req  = '0;
      repeat (2) @(negedge clk);

      chk("rst_lfsr_en", 32'(bus0.lfsr_en), 0);
      chk("rst_gnt", 32'(bus0.gnt), 0);
      chk("rst_gnt_id", 32'(bus0.gnt_id), 0);
      chk("rst_valid", 32'(bus0.rnd_valid), 0);
      chk("rst_data", 32'(bus0.rnd_data), 0);

      // Reset release and warm-up with all requesters active
      bus0.req = 4'b1111;
      rst      = 1'b0;
      #1 chk("en_before_edge", 32'(bus0.lfsr_en), 0);
      @(negedge clk);
      chk("en_rise", 32'(bus0.lfsr_en), 1);
      wait_gnt(0, 20, cyc, smp);
      chk("warm_cycles", 32'(cyc), 9);
      chk("g0_gnt", 32'(bus0.gnt), 32'h1);
      chk("g0_id", 32'(bus0.gnt_id), 0);
      chk("g0_valid", 32'(bus0.rnd_valid), 1);
      chk("g0_data", 32'(bus0.rnd_data), 32'(lfsr_after(8)));

      // Round-robin, exactly GAP cycles apart, wrap back to 0
      for (int k = 0; k < 4; k++) begin
         wait_gnt(0, 20, cyc, smp);
         chk("rr_spacing", 32'(cyc), 8);
         chk("rr_gnt", 32'(bus0.gnt), 32'(rr_exp[k]));
         chk("rr_id", 32'((k + 1) % 4), 32'(bus0.gnt_id));
         chk("rr_data", 32'(bus0.rnd_data), 32'(lfsr_after(16 + 8 * k)));
      end

      // Single requester
      bus0.req = 4'b0100;
      for (int k = 0; k < 2; k++) begin
         wait_gnt(0, 20, cyc, smp);
         chk("single_spacing", 32'(cyc), 8);
         chk("single_gnt", 32'(bus0.gnt), 32'h4);
         chk("single_data", 32'(bus0.rnd_data), 32'(lfsr_after(48 + 8 * k)));
      end

      // Drop-out: one-cycle req pulse inside cooldown is never granted
      bus0.req = '0;
      spur     = 0;
      for (int i = 0; i < 20; i++) begin
         if (i == 2) bus0.req = 4'b0010;
         if (i == 3) bus0.req = 4'b0000;
         @(negedge clk);
         if (bus0.rnd_valid || bus0.gnt != 4'b0000 || bus0.gnt_id != 2'd0) spur++;
      end
      chk("drop_spurious", 32'(spur), 0);

      // Grant (rr_ptr now 3), then async reset mid-cooldown
      bus0.req = 4'b1111;
      wait_gnt(0, 4, cyc, smp);
      chk("pre_rst_latency", 32'(cyc), 1);
      chk("pre_rst_gnt", 32'(bus0.gnt), 32'h8);
      chk("pre_rst_id", 32'(bus0.gnt_id), 3);
      chk("pre_rst_data", 32'(bus0.rnd_data), 32'(smp));
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("async_en", 32'(bus0.lfsr_en), 0);
      chk("async_valid", 32'(bus0.rnd_valid), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 chk("re_en_before", 32'(bus0.lfsr_en), 0);
      @(negedge clk);
      chk("re_en_rise", 32'(bus0.lfsr_en), 1);
      wait_gnt(0, 20, cyc, smp);
      chk("re_warm_cycles", 32'(cyc), 9);
      chk("re_gnt", 32'(bus0.gnt), 32'h1);
      chk("re_data", 32'(bus0.rnd_data), 32'(lfsr_after(8)));

      // GAP=1 instance: back-to-back grants alternating 0,1,0
      bus1.req = 4'b0011;
      rst1     = 1'b0;
      wait_gnt(1, 20, cyc, smp);
      chk("g1_warm_cycles", 32'(cyc), 10);
      chk("g1_gnt_a", 32'(bus1.gnt), 32'h1);
      chk("g1_data_a", 32'(bus1.rnd_data), 32'(lfsr_after(8)));
      @(negedge clk);
      chk("g1_gnt_b", 32'(bus1.gnt), 32'h2);
      chk("g1_id_b", 32'(bus1.gnt_id), 1);
      chk("g1_data_b", 32'(bus1.rnd_data), 32'(lfsr_after(9)));
      @(negedge clk);
      chk("g1_gnt_c", 32'(bus1.gnt), 32'h1);
      chk("g1_id_c", 32'(bus1.gnt_id), 0);
      chk("g1_data_c", 32'(bus1.rnd_data), 32'(lfsr_after(10)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
